// File: rtl/layer_pixel_fetch.sv
// Layer pixel fetch: pipe stage 3 of the GPU.
// Accepts one per-layer read request at a time and performs the memory reads for it.
// A sprite layer needs one RAM read. A text layer needs a RAM read for the character
// code, then a flash read for the glyph bit.
// The stage returns one pixel (colour, opaque flag and layer ID) per request.
module layer_pixel_fetch #(
   parameter int                 ADDR_W    = 26,
   parameter int                 COLOR_W   = 16,
   parameter logic [COLOR_W-1:0] TRANS_KEY = 16'hF81F,
   parameter int                 TIMEOUT   = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reqValid,
   output logic               reqReady,
   input  logic               reqReadRamEn,
   input  logic               reqReadFlashEn,
   input  logic [7:0]         reqLayerId,
   input  logic [ADDR_W-1:0]  reqRamBase,
   input  logic [ADDR_W-1:0]  reqRamOffset,
   input  logic [ADDR_W-1:0]  reqFlashBits,
   input  logic [15:0]        reqGlyphBits,
   input  logic [COLOR_W-1:0] reqTextColor,
   output logic               ramReq,
   output logic [ADDR_W-1:0]  ramAddr,
   input  logic               ramAck,
   input  logic [COLOR_W-1:0] ramData,
   output logic               flashReq,
   output logic [ADDR_W-4:0]  flashAddr,
   input  logic               flashAck,
   input  logic [7:0]         flashData,
   output logic               pixValid,
   input  logic               pixReady,
   output logic [COLOR_W-1:0] pixColor,
   output logic               pixOpaque,
   output logic [7:0]         pixLayerId,
   output logic               fetchTimeout
);

   // Wait counter only needs to reach TIMEOUT-1; the abort fires in that cycle.
   localparam int                CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RAM_RD, FLASH_RD, OUT} state_t;

   state_t               state_q, state_d;
   logic                 ram_req_q, ram_req_d;
   logic                 flash_req_q, flash_req_d;
   logic                 pix_valid_q, pix_valid_d;
   logic                 pix_opaque_q, pix_opaque_d;
   logic                 timeout_q, timeout_d;
   logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
   logic [ADDR_W-4:0]    flash_addr_q, flash_addr_d;
   logic [2:0]           bit_sel_q, bit_sel_d;
   logic [COLOR_W-1:0]   pix_color_q, pix_color_d;
   logic [7:0]           layer_id_q, layer_id_d;
   logic                 flash_en_q, flash_en_d;
   logic [ADDR_W-1:0]    flash_bits_q, flash_bits_d;
   logic [15:0]          glyph_bits_q, glyph_bits_d;
   logic [COLOR_W-1:0]   text_color_q, text_color_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Glyph bit address, built from the character code that is on ramData in the ack cycle.
   logic [ADDR_W-1:0] bit_addr;
   logic              flash_bit;
   assign bit_addr  = flash_bits_q + ADDR_W'(ramData[7:0]) * ADDR_W'(glyph_bits_q);
   assign flash_bit = flashData[3'd7 - bit_sel_q];

   // Next-state logic and the request/result datapath.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
      state_d      = state_q;
      ram_req_d    = ram_req_q;
      flash_req_d  = flash_req_q;
      pix_valid_d  = pix_valid_q;
      pix_opaque_d = pix_opaque_q;
      timeout_d    = 1'b0;
      ram_addr_d   = ram_addr_q;
      flash_addr_d = flash_addr_q;
      bit_sel_d    = bit_sel_q;
      pix_color_d  = pix_color_q;
      layer_id_d   = layer_id_q;
      flash_en_d   = flash_en_q;
      flash_bits_d = flash_bits_q;
      glyph_bits_d = glyph_bits_q;
      text_color_d = text_color_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               layer_id_d   = reqLayerId;
               flash_en_d   = reqReadFlashEn;
               flash_bits_d = reqFlashBits;
               glyph_bits_d = reqGlyphBits;
               text_color_d = reqTextColor;
               cnt_d        = '0;
               if (reqReadRamEn) begin
                  ram_addr_d = reqRamBase + reqRamOffset;
                  ram_req_d  = 1'b1;
                  state_d    = RAM_RD;
               end else begin
                  // No RAM read requested (flash-only is illegal): transparent pixel.
                  pix_color_d  = '0;
                  pix_opaque_d = 1'b0;
                  pix_valid_d  = 1'b1;
                  state_d      = OUT;
               end
            end
         end
         RAM_RD: begin
            if (ramAck) begin
               ram_req_d = 1'b0;
               cnt_d     = '0;
               if (flash_en_q) begin
                  flash_addr_d = bit_addr[ADDR_W-1:3];
                  bit_sel_d    = bit_addr[2:0];
                  flash_req_d  = 1'b1;
                  state_d      = FLASH_RD;
               end else begin
                  pix_opaque_d = (ramData != TRANS_KEY);
                  pix_color_d  = (ramData != TRANS_KEY) ? ramData : '0;
                  pix_valid_d  = 1'b1;
                  state_d      = OUT;
               end
            end else if (cnt_q == CNT_MAX) begin
               ram_req_d    = 1'b0;
               timeout_d    = 1'b1;
               pix_color_d  = '0;
               pix_opaque_d = 1'b0;
               pix_valid_d  = 1'b1;
               state_d      = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLASH_RD: begin
            if (flashAck) begin
               flash_req_d  = 1'b0;
               pix_opaque_d = flash_bit;
               pix_color_d  = flash_bit ? text_color_q : '0;
               pix_valid_d  = 1'b1;
               state_d      = OUT;
            end else if (cnt_q == CNT_MAX) begin
               flash_req_d  = 1'b0;
               timeout_d    = 1'b1;
               pix_color_d  = '0;
               pix_opaque_d = 1'b0;
               pix_valid_d  = 1'b1;
               state_d      = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            if (pixReady) begin
               pix_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; an async reset drops strobes and the result immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ram_req_q    <= 1'b0;
         flash_req_q  <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_opaque_q <= 1'b0;
         timeout_q    <= 1'b0;
         ram_addr_q   <= '0;
         flash_addr_q <= '0;
         bit_sel_q    <= '0;
         pix_color_q  <= '0;
         layer_id_q   <= '0;
         flash_en_q   <= 1'b0;
         flash_bits_q <= '0;
         glyph_bits_q <= '0;
         text_color_q <= '0;
         cnt_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples pre-edge values.
         state_q      <= state_d;
         ram_req_q    <= ram_req_d;
         flash_req_q  <= flash_req_d;
         pix_valid_q  <= pix_valid_d;
         pix_opaque_q <= pix_opaque_d;
         timeout_q    <= timeout_d;
         ram_addr_q   <= ram_addr_d;
         flash_addr_q <= flash_addr_d;
         bit_sel_q    <= bit_sel_d;
         pix_color_q  <= pix_color_d;
         layer_id_q   <= layer_id_d;
         flash_en_q   <= flash_en_d;
         flash_bits_q <= flash_bits_d;
         glyph_bits_q <= glyph_bits_d;
         text_color_q <= text_color_d;
         cnt_q        <= cnt_d;
      end
   end

   assign reqReady     = (state_q == IDLE);
   assign ramReq       = ram_req_q;
   assign ramAddr      = ram_addr_q;
   assign flashReq     = flash_req_q;
   assign flashAddr    = flash_addr_q;
   assign pixValid     = pix_valid_q;
   assign pixColor     = pix_color_q;
   assign pixOpaque    = pix_opaque_q;
   assign pixLayerId   = layer_id_q;
   assign fetchTimeout = timeout_q;

endmodule

// File: tb/tb_layer_pixel_fetch.sv
// Self-checking bench for layer_pixel_fetch.
// A responder process models RAM and flash with programmable wait counts.
// Expected pixels are queued when a request is driven, and a monitor pops and compares
// them on each output handshake.
module tb_layer_pixel_fetch;

   localparam int ADDR_W  = 26;
   localparam int COLOR_W = 16;
   localparam int TMO     = 4;

   logic               clk, reset;
   logic               reqValid, reqReady, reqReadRamEn, reqReadFlashEn;
   logic [7:0]         reqLayerId;
   logic [ADDR_W-1:0]  reqRamBase, reqRamOffset, reqFlashBits;
   logic [15:0]        reqGlyphBits;
   logic [COLOR_W-1:0] reqTextColor;
   logic               ramReq, ramAck;
   logic [ADDR_W-1:0]  ramAddr;
   logic [COLOR_W-1:0] ramData;
   logic               flashReq, flashAck;
   logic [ADDR_W-4:0]  flashAddr;
   logic [7:0]         flashData;
   logic               pixValid, pixReady, pixOpaque, fetchTimeout;
   logic [COLOR_W-1:0] pixColor;
   logic [7:0]         pixLayerId;

   layer_pixel_fetch #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .TRANS_KEY(16'hF81F), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady),
      .reqReadRamEn(reqReadRamEn), .reqReadFlashEn(reqReadFlashEn),
      .reqLayerId(reqLayerId), .reqRamBase(reqRamBase), .reqRamOffset(reqRamOffset),
      .reqFlashBits(reqFlashBits), .reqGlyphBits(reqGlyphBits), .reqTextColor(reqTextColor),
      .ramReq(ramReq), .ramAddr(ramAddr), .ramAck(ramAck), .ramData(ramData),
      .flashReq(flashReq), .flashAddr(flashAddr), .flashAck(flashAck), .flashData(flashData),
      .pixValid(pixValid), .pixReady(pixReady), .pixColor(pixColor), .pixOpaque(pixOpaque),
      .pixLayerId(pixLayerId), .fetchTimeout(fetchTimeout)
   );

   // Field order: ram_en flash_en layer base off fbits glyph tcol ram_wait ram_data
   // flash_wait flash_data exp_ram_addr exp_flash_addr exp_color exp_opaque exp_tmo
   // exp_ram_cyc exp_flash_cyc exp_lat (exp_lat = cycles from accept cycle to first pixValid).
   typedef struct {
      logic               ram_en, flash_en;
      logic [7:0]         layer;
      logic [ADDR_W-1:0]  base, off, fbits;
      logic [15:0]        glyph, tcol;
      int                 ram_wait;
      logic [15:0]        ram_data;
      int                 flash_wait;
      logic [7:0]         flash_data;
      logic [ADDR_W-1:0]  exp_ram_addr;
      logic [ADDR_W-4:0]  exp_flash_addr;
      logic [15:0]        exp_color;
      logic               exp_opaque;
      int                 exp_tmo, exp_ram_cyc, exp_flash_cyc, exp_lat;
   } vec_t;

   typedef struct {
      logic [15:0] color;
      logic        opaque;
      logic [7:0]  layer;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[12];
   vec_t cur;
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, drv_cyc = 0, done_cnt = 0;
   int   tmo_pulses = 0, ram_cyc = 0, flash_cyc = 0;
   int   first_valid_cyc = 0, last_valid_cyc = 0;
   bit   seen_valid = 0, stray_ram = 0, stray_flash = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: acks after cur.*_wait idle request cycles, checks the address in the ack cycle.
   initial begin
      int ram_cnt, flash_cnt;
      ram_cnt = 0; flash_cnt = 0;
      ramAck = 1'b0; flashAck = 1'b0; ramData = '0; flashData = '0;
      forever begin
         tick();
         ramAck    = 1'b0;
         flashAck  = 1'b0;
         ramData   = 16'($urandom);
         flashData = 8'($urandom);
         if (ramReq && !reset) begin
            if (ram_cnt >= cur.ram_wait) begin
               ramAck  = 1'b1;
               ramData = cur.ram_data;
               check("ram_addr", 32'(ramAddr), 32'(cur.exp_ram_addr));
               ram_cnt = 0;
            end else ram_cnt++;
         end else ram_cnt = 0;
         if (flashReq && !reset) begin
            if (flash_cnt >= cur.flash_wait) begin
               flashAck  = 1'b1;
               flashData = cur.flash_data;
               check("flash_addr", 32'(flashAddr), 32'(cur.exp_flash_addr));
               flash_cnt = 0;
            end else flash_cnt++;
         end else flash_cnt = 0;
         ramAck   = ramAck | stray_ram;
         flashAck = flashAck | stray_flash;
      end
   end

   // Output monitor, sampled on the falling edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         seen_valid = 0;
      end else begin
         if (ramReq) ram_cyc++;
         if (flashReq) flash_cyc++;
         if (fetchTimeout) tmo_pulses++;
         if (pixValid && !seen_valid) begin
            seen_valid      = 1;
            first_valid_cyc = cyc;
         end
         if (pixValid && pixReady) begin
            if (sb_q.size() == 0) check("unexpected_pix", 32'd1, 32'd0);
            else begin
               e = sb_q.pop_front();
               check("pix_color", 32'(pixColor), 32'(e.color));
               check("pix_opaque", 32'(pixOpaque), 32'(e.opaque));
               check("pix_layer", 32'(pixLayerId), 32'(e.layer));
            end
            last_valid_cyc = first_valid_cyc;
            seen_valid     = 0;
            done_cnt++;
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 20 && !reqReady; i++) tick();
      check("req_ready", 32'(reqReady), 32'd1);
   endtask

   task automatic drive_req(input vec_t v);
      cur            = v;
      reqValid       = 1'b1;
      reqReadRamEn   = v.ram_en;
      reqReadFlashEn = v.flash_en;
      reqLayerId     = v.layer;
      reqRamBase     = v.base;
      reqRamOffset   = v.off;
      reqFlashBits   = v.fbits;
      reqGlyphBits   = v.glyph;
      reqTextColor   = v.tcol;
      sb_q.push_back('{v.exp_color, v.exp_opaque, v.layer});
      drv_cyc = cyc;
      tick();
      reqValid       = 1'b0;
      reqRamBase     = 26'($urandom);
      reqTextColor   = 16'($urandom);
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
      if (done_cnt == d0) check("pix_done_wait", 32'd0, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int r0, f0, t0, d0;
      pixReady = 1'b1;
      wait_ready();
      r0 = ram_cyc; f0 = flash_cyc; t0 = tmo_pulses; d0 = done_cnt;
      drive_req(v);
      wait_done(d0);
      check("latency", 32'(last_valid_cyc - drv_cyc), 32'(v.exp_lat));
      check("timeout_pulses", 32'(tmo_pulses - t0), 32'(v.exp_tmo));
      check("ram_req_cycles", 32'(ram_cyc - r0), 32'(v.exp_ram_cyc));
      check("flash_req_cycles", 32'(flash_cyc - f0), 32'(v.exp_flash_cyc));
   endtask

   // Result held with pixReady low: outputs must stay put and no new request is accepted.
   task automatic stall_vec(input vec_t v);
      int d0;
      wait_ready();
      pixReady = 1'b0;
      d0 = done_cnt;
      drive_req(v);
      for (int i = 0; i < 20 && !pixValid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(pixValid), 32'd1);
         check("stall_ready", 32'(reqReady), 32'd0);
         check("stall_color", 32'(pixColor), 32'(v.exp_color));
         check("stall_opaque", 32'(pixOpaque), 32'(v.exp_opaque));
         check("stall_layer", 32'(pixLayerId), 32'(v.layer));
         tick();
      end
      pixReady = 1'b1;
      wait_done(d0);
      check("ready_after_stall", 32'(reqReady), 32'd1);
   endtask

   initial begin
      vecs[0]  = '{1, 0, 8'h01, 26'h100, 26'h23, 26'd0, 16'd0, 16'h0, 2, 16'h07E0, 0, 8'h00,
                   26'h123, 23'd0, 16'h07E0, 1, 0, 3, 0, 4};
      vecs[1]  = '{1, 0, 8'h02, 26'h200, 26'h0, 26'd0, 16'd0, 16'h0, 0, 16'hF81F, 0, 8'h00,
                   26'h200, 23'd0, 16'h0000, 0, 0, 1, 0, 2};
      vecs[2]  = '{1, 0, 8'h03, 26'h3FFFFFF, 26'h2, 26'd0, 16'd0, 16'h0, 0, 16'hF81E, 0, 8'h00,
                   26'h1, 23'd0, 16'hF81E, 1, 0, 1, 0, 2};
      vecs[3]  = '{1, 1, 8'h04, 26'h40, 26'h5, 26'd13, 16'd64, 16'h1234, 0, 16'h1241, 0, 8'h04,
                   26'h45, 23'd521, 16'h1234, 1, 0, 1, 1, 3};
      vecs[4]  = '{1, 1, 8'h05, 26'h40, 26'h5, 26'd13, 16'd64, 16'h1234, 0, 16'h0041, 0, 8'hFB,
                   26'h45, 23'd521, 16'h0000, 0, 0, 1, 1, 3};
      vecs[5]  = '{1, 1, 8'h06, 26'h0, 26'h0, 26'h3FFFFFF, 16'd1, 16'hABCD, 0, 16'h0001, 1, 8'h80,
                   26'h0, 23'd0, 16'hABCD, 1, 0, 1, 2, 4};
      vecs[6]  = '{0, 0, 8'h07, 26'h55, 26'h1, 26'd0, 16'd0, 16'h0, 0, 16'h0, 0, 8'h00,
                   26'h0, 23'd0, 16'h0000, 0, 0, 0, 0, 1};
      vecs[7]  = '{0, 1, 8'h08, 26'h55, 26'h1, 26'd8, 16'd8, 16'hFFFF, 0, 16'h0, 0, 8'hFF,
                   26'h0, 23'd0, 16'h0000, 0, 0, 0, 0, 1};
      vecs[8]  = '{1, 0, 8'h09, 26'h10, 26'h1, 26'd0, 16'd0, 16'h0, 3, 16'h0011, 0, 8'h00,
                   26'h11, 23'd0, 16'h0011, 1, 0, 4, 0, 5};
      vecs[9]  = '{1, 0, 8'h0A, 26'h20, 26'h2, 26'd0, 16'd0, 16'h0, 255, 16'h07E0, 0, 8'h00,
                   26'h22, 23'd0, 16'h0000, 0, 1, 4, 0, 5};
      vecs[10] = '{1, 1, 8'h0B, 26'h30, 26'h3, 26'd13, 16'd64, 16'h1234, 0, 16'h0041, 255, 8'h04,
                   26'h33, 23'd521, 16'h0000, 0, 1, 1, 4, 6};
      vecs[11] = '{1, 1, 8'h0C, 26'h30, 26'h3, 26'd13, 16'd64, 16'h1234, 0, 16'h0041, 3, 8'h04,
                   26'h33, 23'd521, 16'h1234, 1, 0, 1, 4, 6};

      cur = vecs[0];
      reset = 1'b1; pixReady = 1'b1;
      reqValid = 1'b0; reqReadRamEn = 1'b0; reqReadFlashEn = 1'b0; reqLayerId = '0;
      reqRamBase = '0; reqRamOffset = '0; reqFlashBits = '0; reqGlyphBits = '0; reqTextColor = '0;
      tick();
      // A request presented during reset must be ignored.
      reqValid = 1'b1; reqReadRamEn = 1'b1; reqLayerId = 8'hEE;
      tick(); tick();
      check("rst_ram_req", 32'(ramReq), 32'd0);
      check("rst_flash_req", 32'(flashReq), 32'd0);
      check("rst_pix_valid", 32'(pixValid), 32'd0);
      check("rst_pix_opaque", 32'(pixOpaque), 32'd0);
      check("rst_timeout", 32'(fetchTimeout), 32'd0);
      check("rst_ram_addr", 32'(ramAddr), 32'd0);
      check("rst_flash_addr", 32'(flashAddr), 32'd0);
      check("rst_pix_color", 32'(pixColor), 32'd0);
      check("rst_pix_layer", 32'(pixLayerId), 32'd0);
      reqValid = 1'b0; reqReadRamEn = 1'b0; reqLayerId = '0;
      @(negedge clk) reset = 1'b0;
      tick();
      check("ready_after_reset", 32'(reqReady), 32'd1);
      check("no_req_after_reset", 32'(ramReq), 32'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Stalled output, with no enables and with a sprite.
      stall_vec(vecs[6]);
      stall_vec(vecs[0]);

      // RAM timeout, then stray acks while idle must do nothing.
      run_vec(vecs[9]);
      stray_ram = 1; stray_flash = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stray_ram_req", 32'(ramReq), 32'd0);
         check("stray_flash_req", 32'(flashReq), 32'd0);
         check("stray_pix_valid", 32'(pixValid), 32'd0);
         check("stray_ready", 32'(reqReady), 32'd1);
      end
      stray_ram = 0; stray_flash = 0;
      run_vec(vecs[3]);

      // Async reset while waiting on flash: strobe drops at once and the request is lost.
      pixReady = 1'b1;
      wait_ready();
      drive_req(vecs[10]);
      for (int i = 0; i < 10 && !flashReq; i++) tick();
      check("flash_req_before_reset", 32'(flashReq), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_flash_req", 32'(flashReq), 32'd0);
      check("mid_rst_ram_req", 32'(ramReq), 32'd0);
      check("mid_rst_pix_valid", 32'(pixValid), 32'd0);
      check("mid_rst_ready", 32'(reqReady), 32'd1);
      sb_q.delete();
      tick(); tick();
      @(negedge clk) reset = 1'b0;
      tick();
      check("ready_after_mid_rst", 32'(reqReady), 32'd1);
      run_vec(vecs[0]);
      run_vec(vecs[3]);

      repeat (3) tick();
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
